// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared constants for the PWM ramp controller: word indices of the PWM slave
// it drives, the controller's own config register map, STATUS bit positions
// and the FSM state encoding.
// -----------------------------------------------------------------------------
package pwm_pkg;

  // PWM slave s0 word map
  localparam logic [1:0] PWM_CTRL   = 2'd0;
  localparam logic [1:0] PWM_PERIOD = 2'd1;
  localparam logic [1:0] PWM_DUTY   = 2'd2;

  // Controller config register map
  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_PERIOD   = 3'd1;
  localparam logic [2:0] REG_TARGET   = 3'd2;
  localparam logic [2:0] REG_STEP     = 3'd3;
  localparam logic [2:0] REG_INTERVAL = 3'd4;
  localparam logic [2:0] REG_CUR_DUTY = 3'd5;

  // CTRL write bits and STATUS read bits
  localparam int CTRL_START  = 0;
  localparam int CTRL_STOP   = 1;
  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;
  localparam int STAT_ABORT  = 2;

  // FSM state encoding
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE      = 3'd0;
  localparam state_t S_WR_PERIOD = 3'd1;
  localparam state_t S_WR_DUTY   = 3'd2;
  localparam state_t S_WAIT      = 3'd3;
  localparam state_t S_DONE      = 3'd4;

endpackage

// File: rtl/pwm_ramp_ctrl_if.sv
// -----------------------------------------------------------------------------
// Bus interfaces of pwm_ramp_ctrl.
//   pwm_ramp_ctrl_cfg_if : Avalon-MM config port (software -> controller).
//                          slave modport = controller side, master = host side.
//   pwm_ramp_ctrl_m_if   : Avalon-MM write-only master port (controller -> PWM
//                          slave s0). master modport = controller side.
// -----------------------------------------------------------------------------
interface pwm_ramp_ctrl_cfg_if #(parameter int DW = 32);
  logic [2:0]    avs_s0_address;
  logic          avs_s0_read;
  logic          avs_s0_write;
  logic [DW-1:0] avs_s0_writedata;
  logic [DW-1:0] avs_s0_readdata;
  logic          avs_s0_waitrequest;

  modport slave (
    input  avs_s0_address, avs_s0_read, avs_s0_write, avs_s0_writedata,
    output avs_s0_readdata, avs_s0_waitrequest
  );

  modport master (
    output avs_s0_address, avs_s0_read, avs_s0_write, avs_s0_writedata,
    input  avs_s0_readdata, avs_s0_waitrequest
  );
endinterface

interface pwm_ramp_ctrl_m_if #(parameter int DW = 32);
  logic [1:0]    avm_m0_address;
  logic          avm_m0_write;
  logic [DW-1:0] avm_m0_writedata;
  logic          avm_m0_waitrequest;

  modport master (
    output avm_m0_address, avm_m0_write, avm_m0_writedata,
    input  avm_m0_waitrequest
  );

  modport slave (
    input  avm_m0_address, avm_m0_write, avm_m0_writedata,
    output avm_m0_waitrequest
  );
endinterface

// File: rtl/pwm_step_calc.sv
// -----------------------------------------------------------------------------
// pwm_step_calc
// Combinational next-duty computation for one ramp step.
//   cur_duty  in  DW  duty value last accepted by the PWM slave
//   target    in  DW  ramp end point
//   step      in  DW  step size (0 = jump straight to target)
//   next_duty out DW  cur_duty moved one step toward target, never past it
// Arithmetic is one bit wider than the data so a carry out of the add or a
// borrow out of the subtract is seen and clamps to target.
// -----------------------------------------------------------------------------
module pwm_step_calc #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] cur_duty,
  input  logic [DW-1:0] target,
  input  logic [DW-1:0] step,
  output logic [DW-1:0] next_duty
);

  function automatic logic [DW-1:0] sat_up(input logic [DW:0] sum,
                                           input logic [DW-1:0] tgt);
    if (sum >= {1'b0, tgt}) return tgt;
    return sum[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] sat_dn(input logic [DW:0] diff,
                                           input logic [DW-1:0] tgt);
    // diff[DW] set means the subtract borrowed (went below zero)
    if (diff[DW] || (diff[DW-1:0] <= tgt)) return tgt;
    return diff[DW-1:0];
  endfunction

  logic [DW:0] sum_w;
  logic [DW:0] diff_w;

  assign sum_w  = {1'b0, cur_duty} + {1'b0, step};
  assign diff_w = {1'b0, cur_duty} - {1'b0, step};

  always_comb begin
    next_duty = target;
    if (step != '0) begin
      if (cur_duty < target)      next_duty = sat_up(sum_w, target);
      else if (cur_duty > target) next_duty = sat_dn(diff_w, target);
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// pwm_ramp_ctrl
// Programs the PWM period, then ramps the PWM duty register toward TARGET in
// STEP increments, pausing INTERVAL cycles between duty writes.
//   clk      in  system clock, rising edge
//   reset_n  in  asynchronous active-low reset
//   s0       cfg interface (slave): 0 CTRL/STATUS, 1 PERIOD, 2 TARGET, 3 STEP,
//            4 INTERVAL, 5 CUR_DUTY (ro), 6-7 read 0. readdata combinational.
//   m0       master interface to PWM slave s0: writes period (1), duty (2).
// -----------------------------------------------------------------------------
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  pwm_ramp_ctrl_cfg_if.slave  s0,
  pwm_ramp_ctrl_m_if.master   m0
);

  logic [DW-1:0] period_r;
  logic [DW-1:0] target_r;
  logic [DW-1:0] step_r;
  logic [DW-1:0] interval_r;
  logic [DW-1:0] cur_duty_r;
  logic [DW-1:0] wait_cnt_r;
  logic [DW-1:0] next_duty;
  logic          busy_r;
  logic          done_r;
  logic          aborted_r;
  logic          stop_pend_r;
  state_t        state_r;

  logic start_req;
  logic stop_req;
  logic stop_seen;
  logic m_accept;

  pwm_step_calc #(.DW(DW)) u_step_calc (
    .cur_duty  (cur_duty_r),
    .target    (target_r),
    .step      (step_r),
    .next_duty (next_duty)
  );

  assign start_req = s0.avs_s0_write && (s0.avs_s0_address == REG_CTRL) &&
                     s0.avs_s0_writedata[CTRL_START];
  assign stop_req  = s0.avs_s0_write && (s0.avs_s0_address == REG_CTRL) &&
                     s0.avs_s0_writedata[CTRL_STOP];
  // A STOP that lands while a master write is outstanding is remembered so
  // the transfer completes before the ramp is abandoned.
  assign stop_seen = stop_req || stop_pend_r;
  assign m_accept  = m0.avm_m0_write && !m0.avm_m0_waitrequest;

  assign s0.avs_s0_waitrequest = 1'b0;

  always_comb begin
    s0.avs_s0_readdata = '0;
    if (s0.avs_s0_read) begin
      case (s0.avs_s0_address)
        REG_CTRL:     s0.avs_s0_readdata = {{(DW-3){1'b0}}, aborted_r, done_r, busy_r};
        REG_PERIOD:   s0.avs_s0_readdata = period_r;
        REG_TARGET:   s0.avs_s0_readdata = target_r;
        REG_STEP:     s0.avs_s0_readdata = step_r;
        REG_INTERVAL: s0.avs_s0_readdata = interval_r;
        REG_CUR_DUTY: s0.avs_s0_readdata = cur_duty_r;
        default:      s0.avs_s0_readdata = '0;
      endcase
    end
  end

  // Master outputs are a pure function of state so reset clears them at once.
  always_comb begin
    m0.avm_m0_write     = 1'b0;
    m0.avm_m0_address   = PWM_CTRL;
    m0.avm_m0_writedata = '0;
    case (state_r)
      S_WR_PERIOD: begin
        m0.avm_m0_write     = 1'b1;
        m0.avm_m0_address   = PWM_PERIOD;
        m0.avm_m0_writedata = period_r;
      end
      S_WR_DUTY: begin
        m0.avm_m0_write     = 1'b1;
        m0.avm_m0_address   = PWM_DUTY;
        m0.avm_m0_writedata = next_duty;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_r    <= '0;
      target_r    <= '0;
      step_r      <= '0;
      interval_r  <= '0;
      cur_duty_r  <= '0;
      wait_cnt_r  <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      aborted_r   <= 1'b0;
      stop_pend_r <= 1'b0;
      state_r     <= S_IDLE;
    end else begin
      // Ramp parameters are frozen while a ramp is in flight.
      if (s0.avs_s0_write && !busy_r) begin
        case (s0.avs_s0_address)
          REG_PERIOD:   period_r   <= s0.avs_s0_writedata;
          REG_TARGET:   target_r   <= s0.avs_s0_writedata;
          REG_STEP:     step_r     <= s0.avs_s0_writedata;
          REG_INTERVAL: interval_r <= s0.avs_s0_writedata;
          default: ;
        endcase
      end

      case (state_r)
        S_IDLE: begin
          stop_pend_r <= 1'b0;
          if (start_req) begin
            state_r   <= S_WR_PERIOD;
            busy_r    <= 1'b1;
            done_r    <= 1'b0;
            aborted_r <= 1'b0;
          end
        end

        S_WR_PERIOD: begin
          if (m_accept) begin
            if (stop_seen) begin
              state_r     <= S_IDLE;
              busy_r      <= 1'b0;
              aborted_r   <= 1'b1;
              stop_pend_r <= 1'b0;
            end else begin
              state_r <= S_WR_DUTY;
            end
          end else if (stop_req) begin
            stop_pend_r <= 1'b1;
          end
        end

        S_WR_DUTY: begin
          if (m_accept) begin
            cur_duty_r <= next_duty;
            if (stop_seen) begin
              state_r     <= S_IDLE;
              busy_r      <= 1'b0;
              aborted_r   <= 1'b1;
              stop_pend_r <= 1'b0;
            end else if (next_duty == target_r) begin
              state_r <= S_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else if (interval_r == '0) begin
              state_r <= S_WR_DUTY;
            end else begin
              state_r    <= S_WAIT;
              wait_cnt_r <= interval_r - 1'b1;
            end
          end else if (stop_req) begin
            stop_pend_r <= 1'b1;
          end
        end

        S_WAIT: begin
          if (stop_req) begin
            state_r   <= S_IDLE;
            busy_r    <= 1'b0;
            aborted_r <= 1'b1;
          end else if (wait_cnt_r == '0) begin
            state_r <= S_WR_DUTY;
          end else begin
            wait_cnt_r <= wait_cnt_r - 1'b1;
          end
        end

        S_DONE: state_r <= S_IDLE;

        default: state_r <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pwm_ramp_ctrl
// Scoreboard bench: the ramp model pushes every expected master write into a
// queue before START; an independent monitor pops and compares on each
// accepted write, and checks hold-stability while the slave stalls.
// -----------------------------------------------------------------------------
module tb_pwm_ramp_ctrl;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pwm_ramp_ctrl_cfg_if #(.DW(DW)) cfg_bus ();
  pwm_ramp_ctrl_m_if   #(.DW(DW)) m_bus ();

  pwm_ramp_ctrl #(.DW(DW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .s0      (cfg_bus),
    .m0      (m_bus)
  );

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] data;
    int          gap;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          last_ref = 0;
  int          acc_cnt = 0;
  logic [31:0] acc_duty = '0;
  int          bp_mode = 0;
  int          grant = 0;
  int          stall_cnt = 0;
  logic [31:0] m_period = '0, m_target = '0, m_step = '0, m_interval = '0, m_cur = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // One ramp step straight from the rules: move toward target by step,
  // never overshoot, step 0 jumps to target.
  function automatic logic [31:0] model_next(input logic [31:0] cur,
                                             input logic [31:0] tgt,
                                             input logic [31:0] stp);
    longint c = cur;
    longint t = tgt;
    longint s = stp;
    if (s == 0 || c == t) return tgt;
    if (c < t) return (c + s >= t) ? tgt : 32'(c + s);
    return (c - s <= t) ? tgt : 32'(c - s);
  endfunction

  task automatic model_ramp();
    logic [31:0] cur;
    logic [31:0] nxt;
    bit first;
    exp_t e;
    e.addr = 2'd1; e.data = m_period; e.gap = 1;
    sbq.push_back(e);
    cur = m_cur;
    first = 1'b1;
    do begin
      nxt = model_next(cur, m_target, m_step);
      e.addr = 2'd2; e.data = nxt; e.gap = first ? 1 : int'(m_interval) + 1;
      sbq.push_back(e);
      cur = nxt;
      first = 1'b0;
    end while (nxt != m_target);
    m_cur = cur;
  endtask

  // Slave stall generator for the master port
  initial begin
    m_bus.avm_m0_waitrequest = 1'b0;
    forever begin
      @(negedge clk);
      if (!m_bus.avm_m0_write) begin
        m_bus.avm_m0_waitrequest = 1'b0;
        stall_cnt = 0;
      end else begin
        case (bp_mode)
          1: begin
            if (stall_cnt < 3) begin
              m_bus.avm_m0_waitrequest = 1'b1;
              stall_cnt++;
            end else begin
              m_bus.avm_m0_waitrequest = 1'b0;
              stall_cnt = 0;
            end
          end
          2: m_bus.avm_m0_waitrequest = 1'($urandom_range(0, 1));
          3: begin
            if (grant > 0) begin
              m_bus.avm_m0_waitrequest = 1'b0;
              grant--;
            end else begin
              m_bus.avm_m0_waitrequest = 1'b1;
            end
          end
          default: m_bus.avm_m0_waitrequest = 1'b0;
        endcase
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    logic        prev_stall;
    logic [1:0]  prev_addr;
    logic [31:0] prev_data;
    exp_t        e;
    prev_stall = 1'b0;
    prev_addr  = '0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!reset_n) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        check("stall_write", 32'(m_bus.avm_m0_write), 32'd1);
        check("stall_addr", 32'(m_bus.avm_m0_address), 32'(prev_addr));
        check("stall_data", m_bus.avm_m0_writedata, prev_data);
      end
      if (m_bus.avm_m0_write && m_bus.avm_m0_waitrequest) begin
        prev_stall = 1'b1;
        prev_addr  = m_bus.avm_m0_address;
        prev_data  = m_bus.avm_m0_writedata;
      end else if (m_bus.avm_m0_write) begin
        prev_stall = 1'b0;
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got addr %0d data 0x%08h, expected no write",
                   m_bus.avm_m0_address, m_bus.avm_m0_writedata);
        end else begin
          e = sbq.pop_front();
          check("mwr_addr", 32'(m_bus.avm_m0_address), 32'(e.addr));
          check("mwr_data", m_bus.avm_m0_writedata, e.data);
          if (bp_mode == 0) check("mwr_gap", 32'(cyc - last_ref), 32'(e.gap));
          if (e.addr == 2'd2) acc_duty = e.data;
        end
        last_ref = cyc;
        acc_cnt++;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cfg_write(input logic [2:0] a, input logic [31:0] d, input bit mark);
    @(negedge clk);
    cfg_bus.avs_s0_address   = a;
    cfg_bus.avs_s0_writedata = d;
    cfg_bus.avs_s0_write     = 1'b1;
    if (mark) last_ref = cyc;
    @(negedge clk);
    cfg_bus.avs_s0_write = 1'b0;
  endtask

  task automatic cfg_read(input logic [2:0] a, output logic [31:0] d);
    cfg_bus.avs_s0_address = a;
    cfg_bus.avs_s0_read    = 1'b1;
    #1;
    d = cfg_bus.avs_s0_readdata;
    cfg_bus.avs_s0_read = 1'b0;
  endtask

  task automatic set_cfg(input logic [31:0] p, input logic [31:0] t,
                         input logic [31:0] s, input logic [31:0] i);
    cfg_write(3'd1, p, 1'b0); m_period   = p;
    cfg_write(3'd2, t, 1'b0); m_target   = t;
    cfg_write(3'd3, s, 1'b0); m_step     = s;
    cfg_write(3'd4, i, 1'b0); m_interval = i;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sbq.size() != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_drain: got %0d writes pending expected 0", name, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic wait_acc(input int target_cnt, input string name);
    int n = 0;
    while (acc_cnt < target_cnt && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (acc_cnt < target_cnt) begin
      checks++;
      failures++;
      $display("FAIL %s_acc: got %0d accepts expected %0d", name, acc_cnt, target_cnt);
    end
  endtask

  task automatic check_status(input string name, input logic [31:0] st);
    logic [31:0] d;
    cfg_read(3'd0, d);
    check({name, "_status"}, d, st);
    cfg_read(3'd5, d);
    check({name, "_cur"}, d, m_cur);
  endtask

  task automatic run_ramp(input string name);
    model_ramp();
    cfg_write(3'd0, 32'h1, 1'b1);
    wait_drain(name);
    check_status(name, 32'h2);
  endtask

  initial begin
    logic [31:0] d;
    int base;
    cfg_bus.avs_s0_address   = '0;
    cfg_bus.avs_s0_read      = 1'b0;
    cfg_bus.avs_s0_write     = 1'b0;
    cfg_bus.avs_s0_writedata = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset state
    for (int a = 0; a < 8; a++) begin
      cfg_read(3'(a), d);
      check($sformatf("reset_reg%0d", a), d, 32'h0);
    end
    check("reset_mwrite", 32'(m_bus.avm_m0_write), 32'd0);
    check("s0_waitreq", 32'(cfg_bus.avs_s0_waitrequest), 32'd0);

    // Up ramp 0 -> 300, step 100, 5-cycle spacing
    set_cfg(32'd1000, 32'd300, 32'd100, 32'd4);
    run_ramp("up");

    // Down ramp with clamp on last step, back-to-back writes
    set_cfg(32'd1000, 32'd50, 32'd100, 32'd0);
    run_ramp("down");

    // STOP while idle changes nothing
    cfg_write(3'd0, 32'h2, 1'b0);
    check_status("stop_idle", 32'h2);

    // Backpressure: 3 stall cycles per transfer
    bp_mode = 1;
    set_cfg(32'd2000, 32'd600, 32'd100, 32'd2);
    run_ramp("bp");
    bp_mode = 0;

    // Already at target: one duty write of target
    run_ramp("equal");

    // STEP 0: single jump
    set_cfg(32'd1234, 32'd10, 32'd0, 32'd3);
    run_ramp("jump");

    // Config writes and START ignored while busy
    set_cfg(32'd1500, 32'd310, 32'd100, 32'd10);
    model_ramp();
    base = acc_cnt;
    cfg_write(3'd0, 32'h1, 1'b1);
    wait_acc(base + 2, "busy");
    cfg_write(3'd1, 32'd777, 1'b0);
    cfg_write(3'd2, 32'd99999, 1'b0);
    cfg_write(3'd0, 32'h1, 1'b0);
    wait_drain("busy");
    check_status("busy", 32'h2);
    cfg_read(3'd1, d);
    check("busy_period", d, 32'd1500);
    cfg_read(3'd2, d);
    check("busy_target", d, 32'd310);

    // Overflow clamp then underflow clamp
    set_cfg(32'd100, 32'hFFFF_FFF0, 32'h8000_0000, 32'd1);
    run_ramp("ovf");
    set_cfg(32'd100, 32'd5, 32'hF000_0000, 32'd0);
    run_ramp("unf");

    // Unmapped addresses
    cfg_write(3'd6, 32'hDEAD_BEEF, 1'b0);
    cfg_read(3'd6, d);
    check("addr6", d, 32'h0);
    cfg_read(3'd7, d);
    check("addr7", d, 32'h0);

    // STOP during WAIT
    set_cfg(32'd900, 32'd5000, 32'd100, 32'd20);
    model_ramp();
    base = acc_cnt;
    cfg_write(3'd0, 32'h1, 1'b1);
    wait_acc(base + 2, "stopw");
    repeat (5) @(negedge clk);
    cfg_write(3'd0, 32'h2, 1'b0);
    sbq.delete();
    m_cur = acc_duty;
    repeat (30) @(negedge clk);
    check_status("stopw", 32'h4);

    // STOP during a stalled duty write: write completes, then nothing
    set_cfg(32'd800, 32'd3000, 32'd100, 32'd0);
    model_ramp();
    grant = 2;
    bp_mode = 3;
    base = acc_cnt;
    cfg_write(3'd0, 32'h1, 1'b1);
    wait_acc(base + 2, "stops");
    repeat (3) @(negedge clk);
    cfg_write(3'd0, 32'h2, 1'b0);
    repeat (3) @(negedge clk);
    check("stops_held", 32'(m_bus.avm_m0_write), 32'd1);
    cfg_read(3'd0, d);
    check("stops_busy", d, 32'h1);
    grant = 1;
    wait_acc(base + 3, "stops");
    sbq.delete();
    m_cur = acc_duty;
    repeat (30) @(negedge clk);
    bp_mode = 0;
    check_status("stops", 32'h4);

    // Randomized ramps
    for (int r = 0; r < 8; r++) begin
      bp_mode = $urandom_range(0, 2);
      set_cfg($urandom, 32'($urandom_range(0, 4000)),
              ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(100, 1500)),
              32'($urandom_range(0, 3)));
      run_ramp($sformatf("rnd%0d", r));
    end
    bp_mode = 0;

    // Asynchronous reset mid-ramp
    set_cfg(32'd700, m_cur + 32'd2000, 32'd100, 32'd0);
    model_ramp();
    base = acc_cnt;
    cfg_write(3'd0, 32'h1, 1'b1);
    wait_acc(base + 3, "rst");
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("rst_mwrite", 32'(m_bus.avm_m0_write), 32'd0);
    check("rst_maddr", 32'(m_bus.avm_m0_address), 32'd0);
    check("rst_mdata", m_bus.avm_m0_writedata, 32'd0);
    cfg_read(3'd5, d);
    check("rst_cur_async", d, 32'h0);
    cfg_read(3'd1, d);
    check("rst_period_async", d, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    sbq.delete();
    m_cur = '0;
    repeat (10) @(negedge clk);
    for (int a = 0; a < 8; a++) begin
      cfg_read(3'(a), d);
      check($sformatf("post_rst_reg%0d", a), d, 32'h0);
    end
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
